// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - commutation state encodings, FSM states, fault codes and lookup functions
package bldc_pkg;

  localparam logic [2:0] ST_A       = 3'd0;
  localparam logic [2:0] ST_B       = 3'd1;
  localparam logic [2:0] ST_C       = 3'd2;
  localparam logic [2:0] ST_D       = 3'd3;
  localparam logic [2:0] ST_E       = 3'd4;
  localparam logic [2:0] ST_F       = 3'd5;
  localparam logic [2:0] ST_UNKNOWN = 3'd7;

  localparam logic [1:0] FC_DRIVER = 2'b01;
  localparam logic [1:0] FC_HALL   = 2'b10;

  typedef enum logic [1:0] {
    FSM_RUN   = 2'd0,
    FSM_DEAD  = 2'd1,
    FSM_FAULT = 2'd2
  } fsm_t;

  function automatic logic [2:0] hall_to_state(input logic [2:0] h);
    case (h)
      3'b101:  return ST_A;
      3'b100:  return ST_B;
      3'b110:  return ST_C;
      3'b010:  return ST_D;
      3'b011:  return ST_E;
      3'b001:  return ST_F;
      default: return ST_UNKNOWN;
    endcase
  endfunction

  // Returns {H[C,B,A], L[C,B,A]}; reverse drive uses the vector three steps ahead.
  function automatic logic [5:0] drive_vector(input logic [2:0] s, input logic fwd);
    logic [2:0] e;
    if (fwd)
      e = s;
    else
      e = (s >= 3'd3) ? s - 3'd3 : s + 3'd3;
    case (e)
      ST_A:    return 6'b001_010;
      ST_B:    return 6'b001_100;
      ST_C:    return 6'b010_100;
      ST_D:    return 6'b010_001;
      ST_E:    return 6'b100_001;
      ST_F:    return 6'b100_010;
      default: return 6'b000_000;
    endcase
  endfunction

endpackage

// File: rtl/bldc_pwm_gen.sv
// rtl/bldc_pwm_gen.sv - free-running PWM counter with registered compare output
module bldc_pwm_gen
  import bldc_pkg::*;
#(
  parameter int PWM_BITS = 10
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] magnitude,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      pwm_on <= 1'b0;
    end else begin
      cnt    <= cnt + PWM_BITS'(1);
      pwm_on <= (cnt < magnitude);
    end
  end

endmodule

// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step BLDC commutation with dead time, brake/coast, fault latch and step counter
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DUTY_W   = 24,
  parameter int PWM_BITS = 10,
  parameter int MAX_DUTY = 1000,
  parameter int DEADTIME = 1024,
  parameter int STEP_W   = 32
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     brake,
  input  logic signed [DUTY_W-1:0] duty,
  input  logic [2:0]               hall,
  input  logic                     fault_n,
  input  logic                     clear_fault,
  output logic [2:0]               inh,
  output logic [2:0]               inl,
  output logic [2:0]               comm_state,
  output logic                     dir,
  output logic                     fault,
  output logic [1:0]               fault_cause,
  output logic                     hall_skip,
  output logic signed [STEP_W-1:0] step_count
);

  localparam int CNT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  logic [1:0]          fault_sync;
  logic                fault_n_s;
  logic [2:0]          hall_state;
  logic                hall_bad;
  logic [2:0]          fwd_of;
  logic [2:0]          bwd_of;
  logic [DUTY_W-1:0]   duty_abs;
  logic [PWM_BITS-1:0] magnitude;
  logic                pwm_on;
  logic [5:0]          target;
  logic [1:0]          new_cause;
  fsm_t                state, state_n;
  logic [5:0]          applied, applied_n;
  logic [CNT_W-1:0]    dead_cnt, dead_cnt_n;
  logic [1:0]          cause_n;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) fault_sync <= 2'b11;
    else          fault_sync <= {fault_sync[0], fault_n};
  end
  assign fault_n_s = fault_sync[1];

  assign hall_state = hall_to_state(hall);
  assign hall_bad   = (hall_state == ST_UNKNOWN);
  assign fwd_of     = (comm_state == ST_F) ? ST_A : comm_state + 3'd1;
  assign bwd_of     = (comm_state == ST_A) ? ST_F : comm_state - 3'd1;

  // Only valid-to-valid transitions count or flag a skip.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      comm_state <= ST_UNKNOWN;
      step_count <= '0;
      hall_skip  <= 1'b0;
    end else begin
      comm_state <= hall_state;
      hall_skip  <= 1'b0;
      if (comm_state != ST_UNKNOWN && !hall_bad && hall_state != comm_state) begin
        if (hall_state == fwd_of)      step_count <= step_count + STEP_W'(1);
        else if (hall_state == bwd_of) step_count <= step_count - STEP_W'(1);
        else                           hall_skip  <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                             dir <= 1'b1;
    else if (duty[DUTY_W-1])                  dir <= 1'b0;
    else if (duty != '0)                      dir <= 1'b1;
  end

  // Unsigned view of the negated most-negative value is its true magnitude.
  always_comb begin
    duty_abs  = duty[DUTY_W-1] ? $unsigned(-duty) : $unsigned(duty);
    magnitude = (duty_abs > DUTY_W'(MAX_DUTY)) ? PWM_BITS'(MAX_DUTY) : duty_abs[PWM_BITS-1:0];
  end

  bldc_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .magnitude (magnitude),
    .pwm_on    (pwm_on)
  );

  always_comb begin
    target = 6'b000_000;
    if (!enable)                        target = 6'b000_000;
    else if (brake)                     target = 6'b000_111;
    else if (comm_state != ST_UNKNOWN)  target = drive_vector(comm_state, dir);
  end

  assign new_cause = (fault_n_s ? 2'b00 : FC_DRIVER) | ((hall_bad && enable) ? FC_HALL : 2'b00);

  always_comb begin
    state_n    = state;
    applied_n  = applied;
    dead_cnt_n = dead_cnt;
    cause_n    = fault_cause;
    if (new_cause != 2'b00) begin
      state_n = FSM_FAULT;
      cause_n = fault_cause | new_cause;
    end else begin
      case (state)
        FSM_RUN: begin
          if (target != applied) begin
            state_n    = FSM_DEAD;
            dead_cnt_n = CNT_W'(DEADTIME);
            applied_n  = target;
          end
        end
        FSM_DEAD: begin
          if (target != applied) begin
            dead_cnt_n = CNT_W'(DEADTIME);
            applied_n  = target;
          end else if (dead_cnt == '0) begin
            state_n = FSM_RUN;
          end else begin
            dead_cnt_n = dead_cnt - CNT_W'(1);
          end
        end
        FSM_FAULT: begin
          if (clear_fault && fault_n_s && !hall_bad) begin
            state_n    = FSM_DEAD;
            dead_cnt_n = CNT_W'(DEADTIME);
            applied_n  = target;
            cause_n    = 2'b00;
          end
        end
        default: begin
          state_n    = FSM_DEAD;
          dead_cnt_n = CNT_W'(DEADTIME);
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FSM_DEAD;
      applied     <= 6'b000_000;
      dead_cnt    <= CNT_W'(DEADTIME);
      fault_cause <= 2'b00;
    end else begin
      state       <= state_n;
      applied     <= applied_n;
      dead_cnt    <= dead_cnt_n;
      fault_cause <= cause_n;
    end
  end

  assign fault = (state == FSM_FAULT);
  assign inl   = (state == FSM_RUN) ? applied[2:0] : 3'b000;
  assign inh   = (state == FSM_RUN) ? (applied[5:3] & {3{pwm_on}}) : 3'b000;

endmodule

// File: tb/tb_bldc_commutator.sv
// tb/tb_bldc_commutator.sv - directed self-checking bench for bldc_commutator
module tb_bldc_commutator;

  localparam int DUTY_W   = 24;
  localparam int PWM_BITS = 10;
  localparam int MAX_DUTY = 1000;
  localparam int DEADTIME = 16;
  localparam int STEP_W   = 32;

  logic                     CLK = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     enable = 1'b1;
  logic                     brake = 1'b0;
  logic signed [DUTY_W-1:0] duty = 24'sd500;
  logic [2:0]               hall = 3'b101;
  logic                     fault_n = 1'b1;
  logic                     clear_fault = 1'b0;
  logic [2:0]               inh, inl, comm_state;
  logic                     dir, fault, hall_skip;
  logic [1:0]               fault_cause;
  logic signed [STEP_W-1:0] step_count;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bldc_commutator #(
    .DUTY_W(DUTY_W), .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY),
    .DEADTIME(DEADTIME), .STEP_W(STEP_W)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .enable(enable), .brake(brake), .duty(duty),
    .hall(hall), .fault_n(fault_n), .clear_fault(clear_fault), .inh(inh), .inl(inl),
    .comm_state(comm_state), .dir(dir), .fault(fault), .fault_cause(fault_cause),
    .hall_skip(hall_skip), .step_count(step_count)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (inh !== 3'b000) begin failures++; $display("FAIL reset_inh got=%b exp=000", inh); end
    checks++; if (inl !== 3'b000) begin failures++; $display("FAIL reset_inl got=%b exp=000", inl); end
    checks++; if (comm_state !== 3'd7) begin failures++; $display("FAIL reset_comm got=%0d exp=7", comm_state); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", dir); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (fault_cause !== 2'b00) begin failures++; $display("FAIL reset_cause got=%b exp=00", fault_cause); end
    checks++; if (hall_skip !== 1'b0) begin failures++; $display("FAIL reset_skip got=%b exp=0", hall_skip); end
    checks++; if (step_count !== 0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step_count); end
  endtask

  task automatic test_startup();
    int n;
    int off;
    int on_cnt;
    logic bad;
    reset_n = 1'b1;
    n = 0;
    while (comm_state !== 3'd0 && n < 20) begin tick(1); n++; end
    checks++; if (comm_state !== 3'd0) begin failures++; $display("FAIL startup_comm got=%0d exp=0", comm_state); end
    off = 0;
    while (inl === 3'b000 && inh === 3'b000 && off < 100) begin off++; tick(1); end
    checks++; if (off < DEADTIME || off > DEADTIME + 2) begin failures++; $display("FAIL startup_dead got=%0d exp=%0d..%0d", off, DEADTIME, DEADTIME + 2); end
    checks++; if (inl !== 3'b010) begin failures++; $display("FAIL startup_inl got=%b exp=010", inl); end
    on_cnt = 0; bad = 1'b0;
    repeat (1024) begin
      if (inh[0]) on_cnt++;
      if (inh[2:1] !== 2'b00 || inl !== 3'b010) bad = 1'b1;
      tick(1);
    end
    checks++; if (on_cnt != 500) begin failures++; $display("FAIL startup_pwm got=%0d exp=500", on_cnt); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL startup_vector got=%b exp=0", bad); end
  endtask

  task automatic test_steps();
    logic [2:0] fwd_seq [6];
    logic [2:0] rev_seq [6];
    int skips;
    fwd_seq = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    rev_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    duty = 24'sd200;
    skips = 0;
    for (int i = 0; i < 6; i++) begin
      hall = fwd_seq[i];
      repeat (3) begin tick(1); if (hall_skip) skips++; end
    end
    checks++; if (step_count !== 6) begin failures++; $display("FAIL steps_fwd got=%0d exp=6", step_count); end
    for (int i = 0; i < 6; i++) begin
      hall = rev_seq[i];
      repeat (3) begin tick(1); if (hall_skip) skips++; end
    end
    checks++; if (step_count !== 0) begin failures++; $display("FAIL steps_rev got=%0d exp=0", step_count); end
    checks++; if (skips != 0) begin failures++; $display("FAIL steps_skip got=%0d exp=0", skips); end
  endtask

  task automatic test_reverse();
    int n;
    int off;
    int on_cnt;
    logic bad;
    hall = 3'b100; tick(3);
    hall = 3'b110; tick(3);
    duty = 24'sd300; tick(40);
    checks++; if (inl !== 3'b100) begin failures++; $display("FAIL rev_pre_inl got=%b exp=100", inl); end
    checks++; if (step_count !== 2) begin failures++; $display("FAIL rev_pre_step got=%0d exp=2", step_count); end
    duty = -24'sd300;
    n = 0;
    while (inl !== 3'b000 && n < 10) begin tick(1); n++; end
    off = 0;
    while (inl === 3'b000 && off < 100) begin off++; tick(1); end
    checks++; if (off != DEADTIME + 1) begin failures++; $display("FAIL rev_dead got=%0d exp=%0d", off, DEADTIME + 1); end
    checks++; if (inl !== 3'b010) begin failures++; $display("FAIL rev_inl got=%b exp=010", inl); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL rev_dir got=%b exp=0", dir); end
    on_cnt = 0; bad = 1'b0;
    repeat (1024) begin
      if (inh[2]) on_cnt++;
      if (inh[1:0] !== 2'b00) bad = 1'b1;
      tick(1);
    end
    checks++; if (on_cnt != 300) begin failures++; $display("FAIL rev_pwm got=%0d exp=300", on_cnt); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rev_inh_other got=%b exp=0", bad); end
    duty = '0; bad = 1'b0;
    repeat (40) begin if (inl !== 3'b010) bad = 1'b1; tick(1); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL zero_duty_chatter got=%b exp=0", bad); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL zero_duty_dir got=%b exp=0", dir); end
  endtask

  task automatic test_skip_and_hall_fault();
    int pulses;
    duty = 24'sd200;
    hall = 3'b100; tick(3);
    hall = 3'b101; tick(3);
    checks++; if (step_count !== 0) begin failures++; $display("FAIL skip_pre_step got=%0d exp=0", step_count); end
    hall = 3'b110;
    pulses = 0;
    repeat (10) begin tick(1); if (hall_skip) pulses++; end
    checks++; if (pulses != 1) begin failures++; $display("FAIL skip_pulses got=%0d exp=1", pulses); end
    checks++; if (step_count !== 0) begin failures++; $display("FAIL skip_step got=%0d exp=0", step_count); end
    tick(30);
    hall = 3'b111; tick(2);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL hall_fault got=%b exp=1", fault); end
    checks++; if (fault_cause !== 2'b10) begin failures++; $display("FAIL hall_cause got=%b exp=10", fault_cause); end
    checks++; if (inh !== 3'b000 || inl !== 3'b000) begin failures++; $display("FAIL hall_fault_out got=%b/%b exp=000/000", inh, inl); end
    hall = 3'b110; tick(2);
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    checks++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin failures++; $display("FAIL hall_clear got=%b/%b exp=0/00", fault, fault_cause); end
    checks++; if (step_count !== 0) begin failures++; $display("FAIL hall_unknown_step got=%0d exp=0", step_count); end
  endtask

  task automatic test_driver_fault();
    int off;
    tick(30);
    fault_n = 1'b0; tick(4);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL drv_fault got=%b exp=1", fault); end
    checks++; if (fault_cause !== 2'b01) begin failures++; $display("FAIL drv_cause got=%b exp=01", fault_cause); end
    checks++; if (inh !== 3'b000 || inl !== 3'b000) begin failures++; $display("FAIL drv_out got=%b/%b exp=000/000", inh, inl); end
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    fault_n = 1'b1; tick(5);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin failures++; $display("FAIL drv_clear_ignored got=%b/%b exp=1/01", fault, fault_cause); end
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    checks++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin failures++; $display("FAIL drv_clear got=%b/%b exp=0/00", fault, fault_cause); end
    off = 0;
    while (inl === 3'b000 && off < 100) begin off++; tick(1); end
    checks++; if (off != DEADTIME + 1) begin failures++; $display("FAIL drv_dead got=%0d exp=%0d", off, DEADTIME + 1); end
    checks++; if (inl !== 3'b100) begin failures++; $display("FAIL drv_resume_inl got=%b exp=100", inl); end
  endtask

  task automatic test_saturation_brake();
    int on_cnt;
    logic bad;
    duty = {1'b1, {(DUTY_W-1){1'b0}}};
    tick(60);
    checks++; if (inl !== 3'b010 || dir !== 1'b0) begin failures++; $display("FAIL sat_vector got=%b/%b exp=010/0", inl, dir); end
    on_cnt = 0;
    repeat (1024) begin if (inh[2]) on_cnt++; tick(1); end
    checks++; if (on_cnt != MAX_DUTY) begin failures++; $display("FAIL sat_pwm got=%0d exp=%0d", on_cnt, MAX_DUTY); end
    brake = 1'b1; tick(40);
    bad = 1'b0;
    repeat (100) begin if (inh !== 3'b000 || inl !== 3'b111) bad = 1'b1; tick(1); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL brake_out got=%b/%b exp=000/111", inh, inl); end
    enable = 1'b0; tick(40);
    checks++; if (inh !== 3'b000 || inl !== 3'b000) begin failures++; $display("FAIL coast_out got=%b/%b exp=000/000", inh, inl); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL coast_fault got=%b exp=0", fault); end
  endtask

  task automatic test_async_reset();
    brake = 1'b0; enable = 1'b1; tick(60);
    checks++; if (inl !== 3'b010) begin failures++; $display("FAIL prereset_inl got=%b exp=010", inl); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (inh !== 3'b000 || inl !== 3'b000) begin failures++; $display("FAIL async_out got=%b/%b exp=000/000", inh, inl); end
    checks++; if (comm_state !== 3'd7 || dir !== 1'b1) begin failures++; $display("FAIL async_state got=%0d/%b exp=7/1", comm_state, dir); end
    @(negedge CLK);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_steps();
    test_reverse();
    test_skip_and_hall_fault();
    test_driver_fault();
    test_saturation_brake();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
